hack_loader: RTL and testbench

Serial program loader for the HACK system. Consumes a byte stream from the UART receiver, frames it into 16-bit instruction words, and writes them into the 8K-word program RAM through the RAM's write port: `data`, `load`, and a 13-bit `address`. While loading, it holds the CPU in reset. It releases the CPU only after a complete frame with a valid checksum has been written.

---
 rtl/hack_loader.sv | 109 ++++++++++
 tb/tb_hack_loader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hack_loader.sv
// hack_loader: frames a UART byte stream into 16-bit words, writes them to program RAM, gates CPU reset on a verified frame
// Ports: clk/reset (sync, active-high); rx_valid/rx_byte byte strobe in;
// ram_data/ram_load/ram_address RAM write port; cpu_reset, done, error status (all registered).
module hack_loader #(
    parameter int ADDR_W    = 13,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [15:0]       ram_data,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, W_HI, W_LO, CHK, DONE, ERR} state_t;
    state_t state_q, state_d;
    logic [7:0] sum_q, sum_d, hi_q, hi_d;
    logic [15:0] len_q, len_d, data_d, n;
    logic [16:0] cnt_q, cnt_d, cnt_inc;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_d;
    logic load_d, timed;
    always_comb begin
        timed   = state_q inside {LEN_HI, LEN_LO, W_HI, W_LO, CHK};
        n       = {len_q[15:8], rx_byte};
        cnt_inc = cnt_q + 17'd1;
        state_d = state_q;
        sum_d   = sum_q;
        hi_d    = hi_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        data_d  = ram_data;
        // the address advances in the cycle after each write pulse
        addr_d  = ram_load ? ram_address + 1'b1 : ram_address;
        tmo_d   = (!timed || rx_valid) ? '0 : (tmo_q == TW'(TIMEOUT) ? tmo_q : tmo_q + 1'b1);
        if (rx_valid) begin
            unique case (state_q)
                IDLE, DONE, ERR: if (rx_byte == 8'hA5) begin
                    state_d = LEN_HI;
                    sum_d   = '0;
                    cnt_d   = '0;
                    addr_d  = ADDR_W'(BASE_ADDR);
                end
                LEN_HI: begin
                    len_d[15:8] = rx_byte;
                    sum_d       = sum_q + rx_byte;
                    state_d     = LEN_LO;
                end
                LEN_LO: begin
                    len_d   = n;
                    sum_d   = sum_q + rx_byte;
                    state_d = (32'(n) > (32'd1 << ADDR_W)) ? ERR : (n == 16'd0 ? CHK : W_HI);
                end
                W_HI: begin
                    hi_d    = rx_byte;
                    sum_d   = sum_q + rx_byte;
                    state_d = W_LO;
                end
                W_LO: begin
                    sum_d   = sum_q + rx_byte;
                    load_d  = 1'b1;
                    data_d  = {hi_q, rx_byte};
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == {1'b0, len_q}) ? CHK : W_HI;
                end
                CHK: state_d = (rx_byte == sum_q) ? DONE : ERR;
            endcase
        end else if (timed && tmo_q == TW'(TIMEOUT - 1)) begin
            // this idle edge would bring the count to TIMEOUT
            state_d = ERR;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            hi_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            ram_load    <= 1'b0;
            ram_data    <= '0;
            ram_address <= ADDR_W'(BASE_ADDR);
            cpu_reset   <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            hi_q        <= hi_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            ram_load    <= load_d;
            ram_data    <= data_d;
            ram_address <= addr_d;
            cpu_reset   <= state_d != DONE;
            done        <= state_d == DONE;
            error       <= state_d == ERR;
        end
    end
endmodule

// File: tb/tb_hack_loader.sv
// tb_hack_loader: randomized scoreboard bench for hack_loader
module tb_hack_loader;
    localparam int AW  = 13;
    localparam int TMO = 50;
    logic clk = 1'b0, reset = 1'b1, rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [15:0] ram_data;
    logic ram_load, cpu_reset, done, error;
    logic [AW-1:0] ram_address;
    int n_cmp = 0, n_bad = 0;
    logic [AW+15:0] exp_q[$];
    logic [15:0] wq[$];

    hack_loader #(.ADDR_W(AW), .BASE_ADDR(0), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .ram_data(ram_data), .ram_load(ram_load), .ram_address(ram_address),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_load) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got %0h@%0h expected none", ram_data, ram_address);
            end else begin
                check("write", 32'({ram_address, ram_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic status(input string name, input logic d, input logic e, input logic c);
        check({name, "_done"}, 32'(done), 32'(d));
        check({name, "_error"}, 32'(error), 32'(e));
        check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(c));
    endtask

    task automatic send(input logic [7:0] b);
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input bit bad);
        int n, s;
        n = wq.size();
        s = (n >> 8) + (n & 255);
        send(8'hA5);
        status("after_sync", 1'b0, 1'b0, 1'b1);
        send(8'(n >> 8));
        send(8'(n));
        foreach (wq[k]) begin
            exp_q.push_back({AW'(k), wq[k]});
            send(wq[k][15:8]);
            send(wq[k][7:0]);
            s += int'(wq[k][15:8]) + int'(wq[k][7:0]);
        end
        send(8'(s + (bad ? 1 : 0)));
        status(bad ? "bad_frame" : "good_frame", !bad, bad, bad);
        check("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_words(input int n);
        wq = {};
        repeat (n) wq.push_back(16'($urandom));
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_load"}, 32'(ram_load), 32'd0);
        check({name, "_addr"}, 32'(ram_address), 32'd0);
        check({name, "_data"}, 32'(ram_data), 32'd0);
        status(name, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        wq = {16'h1234, 16'hABCD};
        run_frame(1'b0);
        run_frame(1'b1);

        send(8'h00); send(8'hFF); send(8'h5A);
        status("noise", 1'b0, 1'b1, 1'b1);

        wq = {};
        run_frame(1'b0);
        wq = {16'h5555};
        run_frame(1'b0);

        send(8'hA5); send(8'h20); send(8'h01);
        status("oversize", 1'b0, 1'b1, 1'b1);

        send(8'hA5); send(8'h20); send(8'h00);
        status("max_len", 1'b0, 1'b0, 1'b1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check_reset_values("reset_max_len");

        send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
        lat = 0;
        for (int i = 1; i <= TMO + 10 && lat == 0; i++) begin
            @(negedge clk);
            if (error) lat = i;
        end
        check("timeout_latency", 32'(lat), 32'(TMO));
        status("timeout", 1'b0, 1'b1, 1'b1);
        rand_words(3);
        run_frame(1'b0);

        send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
        repeat (2) @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h34;
        reset    = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b0;
        check_reset_values("reset_mid_frame");
        @(negedge clk);
        check("reset_mid_frame_no_load", 32'(ram_load), 32'd0);
        rand_words(2);
        run_frame(1'b0);

        for (int f = 0; f < 12; f++) begin
            repeat ($urandom_range(0, 2)) send(8'($urandom_range(0, 8'hA4)));
            rand_words($urandom_range(0, 6));
            run_frame($urandom_range(0, 3) == 0);
        end

        repeat (4) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
